p2s_lanes: RTL and testbench

P2S_LANES -- requirements
Module: p2s_lanes

---
 rtl/p2s_lanes.sv | 102 ++++++++++
 tb/tb_p2s_lanes.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/p2s_lanes.sv
// p2s_lanes: parallel-to-serial converter splitting an N-bit word into K = N/W lanes of W bits
// Ports: clk, rst (async, active-high)
//   par_data/par_valid/par_ready : parallel word in (valid/ready handshake)
//   ser_data/ser_valid/ser_ready/ser_last : serial beats out, ser_last marks beat K-1
// Every output comes straight from a register.
// Define P2S_SKID_EN to add a one-word holding buffer for back-to-back words with no bubble.
module p2s_lanes #(
  parameter int N = 8,
  parameter int W = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic [W-1:0] ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last
);
  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if ((W < 1) || (W > N) || (N % W != 0)) begin : g_bad_cfg
    $error("p2s_lanes: W must divide N and satisfy 1 <= W <= N");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sh_q, sh_d, word, shifted;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d, last_q, last_d, rdy_q, rdy_d;
  logic           acc, beat, fin, start;

  assign acc     = par_valid & rdy_q;
  assign beat    = valid_q & ser_ready;
  assign fin     = beat & (cnt_q == CW'(K - 1));
  // Zero fill means the register is all zeros once the final lane has left,
  // so ser_data reads 0 in IDLE without extra masking.
  assign shifted = (MSB_FIRST != 0) ? sh_q << W : sh_q >> W;

`ifdef P2S_SKID_EN
  logic [N-1:0] buf_q, buf_d;
  logic         full_q, full_d, load, drain;
  always_comb begin
    // A word arriving on the final-beat edge with the buffer empty goes straight to the shifter.
    start  = ((state_q == IDLE) & acc) | (fin & (full_q | acc));
    word   = full_q ? buf_q : par_data;
    drain  = fin & full_q;
    load   = acc & (state_q == SHIFT) & ~(fin & ~full_q);
    full_d = (full_q & ~drain) | load;
    buf_d  = load ? par_data : buf_q;
    rdy_d  = ~full_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end
`else
  assign start = (state_q == IDLE) & acc;
  assign word  = par_data;
  assign rdy_d = (state_d == IDLE);
`endif

  always_comb begin
    state_d = start ? SHIFT : (fin ? IDLE : state_q);
    sh_d    = start ? word : (beat ? shifted : sh_q);
    cnt_d   = (start | fin) ? '0 : (beat ? cnt_q + CW'(1) : cnt_q);
    valid_d = (state_d == SHIFT);
    last_d  = start ? (K == 1) : (fin ? 1'b0 : (beat ? (cnt_q == CW'(K - 2)) : last_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
    end
  end

  assign par_ready = rdy_q;
  assign ser_valid = valid_q;
  assign ser_last  = last_q;
  assign ser_data  = (MSB_FIRST != 0) ? sh_q[N-1 -: W] : sh_q[W-1:0];
endmodule

// File: tb/tb_p2s_lanes.sv
// tb_p2s_lanes: scoreboard bench for p2s_lanes with three lane configurations sharing clk/rst
module tb_p2s_lanes;
  logic       clk, rst;
  logic [7:0] pd [3];
  logic [2:0] pv, pr, sv, sr, sl;
  logic [0:0] sd1;
  logic [1:0] sd2, sd3;
  logic [2:0] mon_got;
  logic [8:0] pat;
  int tests = 0;
  int fails = 0;
  logic [2:0] q0[$], q1[$], q2[$];

  p2s_lanes #(.N(8), .W(1), .MSB_FIRST(1)) u1 (.clk(clk), .rst(rst), .par_data(pd[0]), .par_valid(pv[0]),
    .par_ready(pr[0]), .ser_data(sd1), .ser_valid(sv[0]), .ser_ready(sr[0]), .ser_last(sl[0]));
  p2s_lanes #(.N(8), .W(2), .MSB_FIRST(0)) u2 (.clk(clk), .rst(rst), .par_data(pd[1]), .par_valid(pv[1]),
    .par_ready(pr[1]), .ser_data(sd2), .ser_valid(sv[1]), .ser_ready(sr[1]), .ser_last(sl[1]));
  p2s_lanes #(.N(8), .W(2), .MSB_FIRST(1)) u3 (.clk(clk), .rst(rst), .par_data(pd[2]), .par_valid(pv[2]),
    .par_ready(pr[2]), .ser_data(sd3), .ser_valid(sv[2]), .ser_ready(sr[2]), .ser_last(sl[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : (k == 1 ? q1.size() : q2.size());
  endfunction

  function automatic logic [2:0] pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // beats packs up to 8 two-bit lane values, first beat in [15:14]
  task automatic expect_beats(input int k, input logic [15:0] beats, input int n, input bit with_last);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      e = {with_last && (i == n - 1), beats[15 - 2*i -: 2]};
      case (k)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    bit ok;
    ok = 0;
    pd[k] = d;
    pv[k] = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = pr[k];
      @(posedge clk);
      #1;
    end
    pv[k] = 1'b0;
    pd[k] = ~d;
    chk($sformatf("accept_u%0d", k), int'(ok), 1);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sv[k] && sr[k]) begin
        mon_got = {sl[k], (k == 0) ? {1'b0, sd1} : ((k == 1) ? sd2 : sd3)};
        if (qsize(k) == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat_u%0d: got %0d expected no beat", k, mon_got);
        end else begin
          chk($sformatf("beat_u%0d", k), int'(mon_got), int'(pop(k)));
        end
      end
    end
  end

  initial begin
    rst = 1;
    pv = '0;
    sr = 3'b111;
    for (int i = 0; i < 3; i++) pd[i] = '0;
    @(negedge clk);
    chk("rst_ready", int'(pr), 0);
    chk("rst_valid", int'(sv), 0);
    chk("rst_last", int'(sl), 0);
    chk("rst_data", int'({sd1, sd2, sd3}), 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_before_edge", int'(pr), 0);
    @(posedge clk); #1;
    chk("ready_after_release", int'(pr), 7);
    // 0x3E, W=1 MSB first
    expect_beats(0, {2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0}, 8, 1);
    send(0, 8'h3E);
    // 0x3E, W=2 LSB first
    expect_beats(1, {2'd2, 2'd3, 2'd3, 2'd0, 8'd0}, 4, 1);
    send(1, 8'h3E);
    repeat (6) @(posedge clk);
    #1;
    chk("idle_valid_u1", int'(sv[1]), 0);
    chk("idle_data_u1", int'(sd2), 0);
    chk("idle_last_u1", int'(sl[1]), 0);
    // 0x34 with a 3-cycle stall on beat 1
    expect_beats(2, {2'd0, 2'd3, 2'd1, 2'd0, 8'd0}, 4, 1);
    send(2, 8'h34);
    @(posedge clk); #1;
    sr[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_data_%0d", i), int'(sd3), 3);
      chk($sformatf("stall_valid_%0d", i), int'(sv[2]), 1);
      chk($sformatf("stall_last_%0d", i), int'(sl[2]), 0);
    end
    @(posedge clk); #1;
    sr[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // back-to-back words 0x3E then 0x34
    expect_beats(2, {2'd0, 2'd3, 2'd3, 2'd2, 8'd0}, 4, 1);
    expect_beats(2, {2'd0, 2'd3, 2'd1, 2'd0, 8'd0}, 4, 1);
    send(2, 8'h3E);
    fork
      send(2, 8'h34);
    join_none
    for (int i = 8; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = sv[2];
    end
`ifdef P2S_SKID_EN
    chk("b2b_valid_pattern", int'(pat), 9'b111111110);
`else
    chk("b2b_valid_pattern", int'(pat), 9'b111101111);
`endif
    repeat (6) @(posedge clk);
    #1;
    // reset in the middle of 0xA5
    expect_beats(0, {2'd1, 2'd0, 2'd1, 10'd0}, 3, 0);
    send(0, 8'hA5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", int'(sv[0]), 0);
    chk("midrst_ready", int'(pr[0]), 0);
    chk("midrst_data", int'(sd1), 0);
    chk("beats_before_reset", q0.size(), 0);
    @(posedge clk); #1;
    rst = 0;
    expect_beats(0, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1}, 8, 1);
    send(0, 8'h0F);
    for (int c = 0; c < 100 && (q0.size() + q1.size() + q2.size()) != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("left_u0", q0.size(), 0);
    chk("left_u1", q1.size(), 0);
    chk("left_u2", q2.size(), 0);
    chk("final_idle_valid", int'(sv), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
